// File: rtl/rand_stream_gen_pkg.sv
// ---------------------------------------------------------------------------
// rand_stream_gen_pkg
// Shared definitions for the random stream generator:
//   LANE_MIX_C  - golden-ratio constant used to decorrelate lane seeds
//   xs32_step   - one xorshift32 step (13 / 17 / 5)
//   lane_seed   - per-lane seed derived from a 32-bit base seed
// ---------------------------------------------------------------------------
package rand_stream_gen_pkg;

  localparam logic [31:0] LANE_MIX_C = 32'h9E37_79B9;

  // One xorshift32 step; all shifts stay within 32 bits.
  function automatic logic [31:0] xs32_step(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Seed for lane idx: base ^ (idx * LANE_MIX_C). xorshift32 has a fixed
  // point at zero, so a zero seed is replaced by 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] base,
                                            input int unsigned idx);
    logic [31:0] idx_v;
    logic [31:0] seed_v;
    idx_v  = idx;
    seed_v = base ^ (idx_v * LANE_MIX_C);
    if (seed_v == 32'h0000_0000) begin
      seed_v = 32'h0000_0001;
    end else begin
      seed_v = seed_v;
    end
    return seed_v;
  endfunction

endpackage

// File: rtl/rand_lane_xs32.sv
// ---------------------------------------------------------------------------
// rand_lane_xs32
// One 32-bit xorshift32 lane.
//   clk_i       clock
//   rst_i       asynchronous active-high reset; loads the seed from SEED
//   load_i      reseed strobe (wins over step_i)
//   load_base_i base seed used when load_i is high
//   step_i      advance the lane by one xorshift32 step
//   state_o     current lane state
// ---------------------------------------------------------------------------
module rand_lane_xs32
  import rand_stream_gen_pkg::*;
#(
  parameter int unsigned LANE_IDX = 0,
  parameter logic [31:0] SEED     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_base_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Next-state selection: reseed, step or hold.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = lane_seed(load_base_i, LANE_IDX);
    end else if (step_i) begin
      state_d = xs32_step(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // Lane state register; reset restarts the lane from the parameter seed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= lane_seed(SEED, LANE_IDX);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rand_stream_gen.sv
// ---------------------------------------------------------------------------
// rand_stream_gen
// Prefetching random word generator. LANES = WIDTH/32 xorshift32 lanes form
// each word; words are prefetched into a DEPTH-entry circular buffer.
//   CLK              clock
//   RESET            asynchronous active-high reset
//   REQ_WRITE        consume request; pops the head word when valid
//   RESEED_WRITE     reseed strobe; flushes the buffer, overrides push/pop
//   RESEED_DATA      new 32-bit base seed
//   RESP_READ        head word of the buffer
//   RESP_READ_VALID  buffer non-empty
//   DONE             buffer full
// ---------------------------------------------------------------------------
module rand_stream_gen
  import rand_stream_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] SEED  = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_WRITE,
  input  logic             RESEED_WRITE,
  input  logic [31:0]      RESEED_DATA,
  output logic [WIDTH-1:0] RESP_READ,
  output logic             RESP_READ_VALID,
  output logic             DONE
);

  localparam int unsigned LANES = WIDTH / 32;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] lane_word_s;

  assign full_s = (count_q == CNT_W'(DEPTH));

  // Lane array; lane 0 occupies the least significant 32 bits of the word.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rand_lane_xs32 #(
      .LANE_IDX (g),
      .SEED     (SEED)
    ) u_lane (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .load_i      (RESEED_WRITE),
      .load_base_i (RESEED_DATA),
      .step_i      (push_s),
      .state_o     (lane_word_s[g*32 +: 32])
    );
  end

  // Push/pop decisions and pointer/count next state. A full buffer may still
  // push when it pops in the same cycle, which keeps one word per cycle.
  always_comb begin
    pop_s    = 1'b0;
    push_s   = 1'b0;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (RESEED_WRITE) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      pop_s  = REQ_WRITE && (count_q != '0);
      push_s = !full_s || pop_s;
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer storage; entries are cleared on reset so the head reads 0 until
  // written.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= lane_word_s;
    end
  end

  assign RESP_READ       = mem_q[rd_ptr_q];
  assign RESP_READ_VALID = (count_q != '0);
  assign DONE            = full_s;

endmodule

// File: tb/tb_rand_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_rand_stream_gen
// Drives two generators (32-bit / SEED=1 and 64-bit / SEED=0) with the same
// stimulus and compares both against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_rand_stream_gen;

  localparam int          DEPTH = 4;
  localparam logic [31:0] MIX   = 32'h9E37_79B9;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_WRITE = 1'b0;
  logic        RESEED_WRITE = 1'b0;
  logic [31:0] RESEED_DATA = 32'h0;

  logic [31:0] a_read;
  logic        a_valid, a_done;
  logic [63:0] b_read;
  logic        b_valid, b_done;

  int total = 0;
  int bad   = 0;

  rand_stream_gen #(.WIDTH(32), .DEPTH(DEPTH), .SEED(32'h0000_0001)) dut_a (
    .CLK(CLK), .RESET(RESET), .REQ_WRITE(REQ_WRITE), .RESEED_WRITE(RESEED_WRITE),
    .RESEED_DATA(RESEED_DATA), .RESP_READ(a_read), .RESP_READ_VALID(a_valid),
    .DONE(a_done)
  );

  rand_stream_gen #(.WIDTH(64), .DEPTH(DEPTH), .SEED(32'h0000_0000)) dut_b (
    .CLK(CLK), .RESET(RESET), .REQ_WRITE(REQ_WRITE), .RESEED_WRITE(RESEED_WRITE),
    .RESEED_DATA(RESEED_DATA), .RESP_READ(b_read), .RESP_READ_VALID(b_valid),
    .DONE(b_done)
  );

  always #5 CLK = ~CLK;

  // ---- reference model: lane values plus a word queue per instance ----
  logic [31:0] ref_a_lane;
  logic [31:0] ref_b_lane [2];
  logic [31:0] ref_a_q [$];
  logic [63:0] ref_b_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] seed_of(input logic [31:0] base, input logic [31:0] i);
    logic [31:0] s;
    s = base ^ (i * MIX);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic model_reset();
    ref_a_lane    = seed_of(32'h1, 32'd0);
    ref_b_lane[0] = seed_of(32'h0, 32'd0);
    ref_b_lane[1] = seed_of(32'h0, 32'd1);
    ref_a_q.delete();
    ref_b_q.delete();
  endtask

  task automatic model_clock(input logic req, input logic rs, input logic [31:0] rd);
    bit pop_a, push_a, pop_b, push_b;
    if (rs) begin
      ref_a_q.delete();
      ref_b_q.delete();
      ref_a_lane    = seed_of(rd, 32'd0);
      ref_b_lane[0] = seed_of(rd, 32'd0);
      ref_b_lane[1] = seed_of(rd, 32'd1);
    end else begin
      pop_a  = req && (ref_a_q.size() != 0);
      push_a = (ref_a_q.size() < DEPTH) || pop_a;
      pop_b  = req && (ref_b_q.size() != 0);
      push_b = (ref_b_q.size() < DEPTH) || pop_b;
      if (pop_a) void'(ref_a_q.pop_front());
      if (pop_b) void'(ref_b_q.pop_front());
      if (push_a) begin
        ref_a_q.push_back(ref_a_lane);
        ref_a_lane = xs(ref_a_lane);
      end
      if (push_b) begin
        ref_b_q.push_back({ref_b_lane[1], ref_b_lane[0]});
        ref_b_lane[0] = xs(ref_b_lane[0]);
        ref_b_lane[1] = xs(ref_b_lane[1]);
      end
    end
  endtask

  task automatic check_outputs();
    check("a_valid", 64'(a_valid), 64'(ref_a_q.size() != 0));
    check("a_done",  64'(a_done),  64'(ref_a_q.size() == DEPTH));
    check("b_valid", 64'(b_valid), 64'(ref_b_q.size() != 0));
    check("b_done",  64'(b_done),  64'(ref_b_q.size() == DEPTH));
    if (ref_a_q.size() != 0) check("a_read", 64'(a_read), 64'(ref_a_q[0]));
    if (ref_b_q.size() != 0) check("b_read", b_read, ref_b_q[0]);
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, then compare.
  task automatic step(input logic req, input logic rs, input logic [31:0] rd);
    REQ_WRITE    = req;
    RESEED_WRITE = rs;
    RESEED_DATA  = rd;
    @(posedge CLK);
    model_clock(req, rs, rd);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_read"},  64'(a_read),  64'h0);
    check({tag, "_a_valid"}, 64'(a_valid), 64'h0);
    check({tag, "_a_done"},  64'(a_done),  64'h0);
    check({tag, "_b_read"},  b_read,       64'h0);
    check({tag, "_b_valid"}, 64'(b_valid), 64'h0);
    check({tag, "_b_done"},  64'(b_done),  64'h0);
  endtask

  initial begin
    int thresh;
    logic req, rs;
    logic [31:0] rd;

    model_reset();
    repeat (2) @(negedge CLK);
    check_zero("reset");

    // Release reset with a request while empty: ignored, first push happens.
    RESET = 1'b0;
    step(1'b1, 1'b0, 32'h0);
    check("first_word_a", 64'(a_read), 64'h0000_0000_0000_0001);
    check("first_word_b", b_read, {MIX, 32'h0000_0001});
    repeat (3) step(1'b0, 1'b0, 32'h0);
    check("full_done_a", 64'(a_done), 64'h1);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    check("head_holds_a", 64'(a_read), 64'h1);

    // Sustained consumption.
    step(1'b1, 1'b0, 32'h0);
    check("second_word_a", 64'(a_read), 64'h0004_2021);
    repeat (10) step(1'b1, 1'b0, 32'h0);

    // Randomized traffic with occasional reseeds.
    thresh = 50;
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) thresh = (i / 50 % 3 == 0) ? 15 : ((i / 50 % 3 == 1) ? 50 : 90);
      req = ($urandom_range(0, 99) < thresh);
      rs  = ($urandom_range(0, 24) == 0);
      rd  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(req, rs, rd);
    end

    // Reseed on a full buffer together with a pop.
    repeat (5) step(1'b0, 1'b0, 32'h0);
    check("prefull_a", 64'(a_done), 64'h1);
    step(1'b1, 1'b1, 32'h1);
    check("reseed_valid_a", 64'(a_valid), 64'h0);
    check("reseed_done_a",  64'(a_done),  64'h0);
    check("reseed_valid_b", 64'(b_valid), 64'h0);
    step(1'b0, 1'b0, 32'h0);
    check("reseed_word_a", 64'(a_read), 64'h1);
    check("reseed_word_b", b_read, {32'h9E37_79B8, 32'h0000_0001});

    // Asynchronous reset between edges mid-stream.
    repeat (6) step(1'b1, 1'b0, 32'h0);
    #2;
    RESET = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    check("restart_word_a", 64'(a_read), 64'h1);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("restart_second_a", 64'(a_read), 64'h0004_2021);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rand_stream_gen.md
RAND_STREAM_GEN -- requirements
Module: rand_stream_gen

Interface
REQ-001 Parameter WIDTH, default 32, output word width; SHALL be a multiple of 32; LANES = WIDTH/32.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; SHALL be a power of two, at least 2.
REQ-003 Parameter SEED, default 0, 32-bit base seed.
REQ-004 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 REQ_WRITE  input  1  consume request; pops the head word when RESP_READ_VALID=1.
REQ-007 RESEED_WRITE  input  1  reseed strobe.
REQ-008 RESEED_DATA  input  32  new base seed, sampled when RESEED_WRITE=1.
REQ-009 RESP_READ  output  WIDTH  head word of the prefetch buffer.
REQ-010 RESP_READ_VALID  output  1  buffer non-empty.
REQ-011 DONE  output  1  buffer full (count == DEPTH).

Function
REQ-012 Each lane i SHALL hold a 32-bit xorshift32 state; step: x^=x<<13; x^=x>>17; x^=x<<5; all shifts are 32-bit, truncated.
REQ-013 Lane i seed value SHALL be base ^ (i * 32'h9E3779B9), truncated to 32 bits; a zero result SHALL be replaced by 32'h00000001.
REQ-014 Generated word SHALL be {lane[LANES-1], ..., lane[0]}; lane 0 is bits [31:0].
REQ-015 Push: on a cycle with count<DEPTH, or with count==DEPTH and a pop in the same cycle, the current lane states SHALL be written at the tail and every lane SHALL advance one step.
REQ-016 With no push, lane states SHALL hold.
REQ-017 Pop: REQ_WRITE=1 with count!=0 SHALL advance the head; REQ_WRITE with count==0 SHALL be ignored, with no state change except a normal push.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-019 RESP_READ SHALL equal the buffer head entry; it is undefined-free: the value is the stored word, or 0 if never written.
REQ-020 RESP_READ_VALID = (count!=0); DONE = (count==DEPTH); both are registered-state derived with no combinational path from inputs.
REQ-021 RESEED_WRITE=1 SHALL take priority over push and pop:
  - count <= 0; pointers <= 0
  - lanes <= seeds derived from RESEED_DATA per REQ-013
  - no word pushed or popped that cycle
REQ-022 After a reseed, the first pushed word SHALL be the new seed states, one cycle after the reseed edge.
REQ-023 Sustained throughput: one word per cycle when REQ_WRITE is held high and the buffer is non-empty.

Reset
REQ-024 While RESET=1, independent of CLK:
  - count = 0; pointers = 0
  - buffer entries = 0
  - lanes = seeds from parameter SEED
  - RESP_READ = 0; RESP_READ_VALID = 0; DONE = 0
REQ-025 The first posedge after RESET falls SHALL push; RESP_READ_VALID=1 after that edge.
REQ-026 RESET asserted mid-operation SHALL discard buffered words; the sequence restarts from SEED.

Structure
REQ-027 Shared package SHALL hold the xorshift32 step function, the lane-seed function (REQ-013) and the constant 32'h9E3779B9.
REQ-028 One sub-module SHALL exist, rand_lane_xs32 (one 32-bit lane: state register, seed load, step enable), instantiated LANES times via generate.
REQ-029 Buffer and pointer/count logic SHALL remain in rand_stream_gen.

Verification
REQ-030 WIDTH=32, SEED=1, release RESET, no REQ_WRITE -> RESP_READ=0x00000001 and VALID=1 after edge 1; DONE=1 after edge 4; RESP_READ stays 0x00000001.
REQ-031 Same configuration, then REQ_WRITE held high -> consecutive RESP_READ values 0x00000001, 0x00042021, ...; one new word per cycle; no gaps once full.
REQ-032 SEED=0 -> first word 0x00000001 (zero-seed substitution); WIDTH=64 -> upper lane of first word = 0x9E3779B9.
REQ-033 Full buffer, RESEED_WRITE=1 with RESEED_DATA=1 and REQ_WRITE=1 in the same cycle -> next cycle VALID=0 and DONE=0; following cycle RESP_READ=0x00000001.
REQ-034 REQ_WRITE pulsed while empty, e.g. in the reset-release cycle -> no underflow; count is never negative; sequence is unaffected.
REQ-035 RESET asserted asynchronously between edges mid-stream -> outputs are 0 immediately; the stream after release repeats REQ-031 exactly.
